// File: rtl/key_stream_tx.sv
// Serves a loaded key word one bit per request, with an optional lease limit.
// Each response appears 1 cycle after key_req; loads are accepted only in IDLE/EXPIRED.
module key_stream_tx #(
  parameter int KEY_W    = 16,
  parameter int MAX_USES = 0,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [KEY_W-1:0]         key_data,
  input  logic                     key_valid,
  output logic                     key_ready,
  input  logic                     zeroize,
  input  logic                     key_req,
  output logic                     keyinput,
  output logic                     key_bit_vld,
  output logic                     key_err,
  output logic                     armed,
  output logic                     expired,
  output logic [$clog2(KEY_W)-1:0] bit_ptr,
  output logic [CNT_W-1:0]         use_cnt
);

  localparam int PTR_W = $clog2(KEY_W);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] EXPIRED = 2'd2;

  logic [1:0]       state;
  logic [KEY_W-1:0] key_reg;
  logic             load;
  logic             serve;
  logic [CNT_W:0]   cnt_inc;
  logic             last_use;

  assign load      = key_valid & key_ready;
  assign serve     = key_req & (state == ARMED);
  assign cnt_inc   = {1'b0, use_cnt} + (CNT_W+1)'(1);
  assign last_use  = (MAX_USES != 0) && (cnt_inc == (CNT_W+1)'(MAX_USES));

  assign key_ready = (state == IDLE) || (state == EXPIRED);
  assign armed     = (state == ARMED);
  assign expired   = (state == EXPIRED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      key_reg     <= '0;
      bit_ptr     <= '0;
      use_cnt     <= '0;
      keyinput    <= 1'b0;
      key_bit_vld <= 1'b0;
      key_err     <= 1'b0;
    end else begin
      key_bit_vld <= 1'b0;
      key_err     <= 1'b0;

      // Responses are judged on the pre-edge state; zeroize turns any request into an error.
      if (key_req) begin
        key_bit_vld <= 1'b1;
        if (serve && !zeroize) begin
          keyinput <= key_reg[bit_ptr];
        end else begin
          keyinput <= 1'b0;
          key_err  <= 1'b1;
        end
      end

      if (zeroize) begin
        state   <= IDLE;
        key_reg <= '0;
        bit_ptr <= '0;
        use_cnt <= '0;
      end else if (load) begin
        state   <= ARMED;
        key_reg <= key_data;
        bit_ptr <= '0;
        use_cnt <= '0;
      end else if (serve) begin
        bit_ptr <= (bit_ptr == PTR_W'(KEY_W-1)) ? '0 : bit_ptr + PTR_W'(1);
        if (use_cnt != '1)
          use_cnt <= cnt_inc[CNT_W-1:0];
        if (last_use) begin
          state   <= EXPIRED;
          key_reg <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_stream_tx.sv
// Directed bench for key_stream_tx: an unlimited instance and a MAX_USES=4 instance share stimulus.
module tb_key_stream_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] key_data;
  logic        key_valid;
  logic        zeroize;
  logic        key_req;

  logic        key_ready, keyinput, key_bit_vld, key_err, armed, expired;
  logic [3:0]  bit_ptr;
  logic [15:0] use_cnt;

  logic        l_key_ready, l_keyinput, l_key_bit_vld, l_key_err, l_armed, l_expired;
  logic [3:0]  l_bit_ptr;
  logic [15:0] l_use_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_stream_tx #(.KEY_W(16), .MAX_USES(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .key_data(key_data), .key_valid(key_valid),
    .key_ready(key_ready), .zeroize(zeroize), .key_req(key_req),
    .keyinput(keyinput), .key_bit_vld(key_bit_vld), .key_err(key_err),
    .armed(armed), .expired(expired), .bit_ptr(bit_ptr), .use_cnt(use_cnt)
  );

  key_stream_tx #(.KEY_W(16), .MAX_USES(4), .CNT_W(16)) dut_l (
    .clk(clk), .rst(rst), .key_data(key_data), .key_valid(key_valid),
    .key_ready(l_key_ready), .zeroize(zeroize), .key_req(key_req),
    .keyinput(l_keyinput), .key_bit_vld(l_key_bit_vld), .key_err(l_key_err),
    .armed(l_armed), .expired(l_expired), .bit_ptr(l_bit_ptr), .use_cnt(l_use_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_and_load(input logic [15:0] k);
    zeroize = 1'b1;
    step();
    zeroize   = 1'b0;
    key_data  = k;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_data = '0; key_valid = 1'b0; zeroize = 1'b0; key_req = 1'b0;
    step();
    step();
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got %b want 1", key_ready); end
    checks++; if ({keyinput, key_bit_vld, key_err, armed, expired} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {keyinput, key_bit_vld, key_err, armed, expired}); end
    checks++; if ({bit_ptr, use_cnt} !== 20'h0) begin errors++; $display("FAIL reset_counters got %h want 00000", {bit_ptr, use_cnt}); end
    rst = 1'b0;
    step();
    checks++; if (key_bit_vld !== 1'b0) begin errors++; $display("FAIL reset_release_vld got %b want 0", key_bit_vld); end
  endtask

  task automatic test_idle_req();
    key_req = 1'b1;
    step();
    key_req = 1'b0;
    checks++; if ({key_bit_vld, key_err, keyinput} !== 3'b110) begin errors++; $display("FAIL idle_req vld/err/bit got %b want 110", {key_bit_vld, key_err, keyinput}); end
    checks++; if ({armed, expired, key_ready} !== 3'b001) begin errors++; $display("FAIL idle_req state got %b want 001", {armed, expired, key_ready}); end
    step();
    checks++; if ({key_bit_vld, key_err} !== 2'b00) begin errors++; $display("FAIL idle_req_pulse got %b want 00", {key_bit_vld, key_err}); end
  endtask

  task automatic test_stream();
    logic exp_bits [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
    clear_and_load(16'hA5C3);
    checks++; if ({armed, key_ready} !== 2'b10) begin errors++; $display("FAIL stream_armed got %b want 10", {armed, key_ready}); end
    key_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++; if ({key_bit_vld, key_err, keyinput} !== {2'b10, exp_bits[i]}) begin errors++; $display("FAIL stream_bit%0d got %b want %b", i, {key_bit_vld, key_err, keyinput}, {2'b10, exp_bits[i]}); end
    end
    key_req = 1'b0;
    checks++; if ({bit_ptr, use_cnt} !== {4'd0, 16'd16}) begin errors++; $display("FAIL stream_wrap ptr/cnt got %0d/%0d want 0/16", bit_ptr, use_cnt); end
    step();
    checks++; if ({key_bit_vld, keyinput} !== 2'b01) begin errors++; $display("FAIL stream_hold vld/bit got %b want 01", {key_bit_vld, keyinput}); end
    key_req = 1'b1;
    step();
    key_req = 1'b0;
    checks++; if ({key_bit_vld, keyinput} !== 2'b11) begin errors++; $display("FAIL stream_17th got %b want 11", {key_bit_vld, keyinput}); end
    checks++; if ({bit_ptr, use_cnt, expired} !== {4'd1, 16'd17, 1'b0}) begin errors++; $display("FAIL stream_17th ptr/cnt/exp got %0d/%0d/%b want 1/17/0", bit_ptr, use_cnt, expired); end
  endtask

  task automatic test_zeroize();
    clear_and_load(16'hA5C3);
    key_req = 1'b1;
    repeat (3) step();
    checks++; if ({bit_ptr, use_cnt} !== {4'd3, 16'd3}) begin errors++; $display("FAIL zeroize_pre ptr/cnt got %0d/%0d want 3/3", bit_ptr, use_cnt); end
    zeroize = 1'b1;
    step();
    zeroize = 1'b0; key_req = 1'b0;
    checks++; if ({key_bit_vld, key_err, keyinput, armed} !== 4'b1100) begin errors++; $display("FAIL zeroize_req vld/err/bit/armed got %b want 1100", {key_bit_vld, key_err, keyinput, armed}); end
    checks++; if ({bit_ptr, use_cnt} !== 20'h0) begin errors++; $display("FAIL zeroize_counters got %h want 00000", {bit_ptr, use_cnt}); end
    step();
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL zeroize_key_ready got %b want 1", key_ready); end
  endtask

  task automatic test_load_req();
    zeroize = 1'b1;
    step();
    zeroize = 1'b0;
    key_data = 16'h0001; key_valid = 1'b1; key_req = 1'b1;
    step();
    key_valid = 1'b0; key_req = 1'b0;
    checks++; if ({key_bit_vld, key_err, keyinput} !== 3'b110) begin errors++; $display("FAIL load_req_err got %b want 110", {key_bit_vld, key_err, keyinput}); end
    checks++; if ({armed, use_cnt} !== {1'b1, 16'd0}) begin errors++; $display("FAIL load_req_armed armed/cnt got %b/%0d want 1/0", armed, use_cnt); end
    key_req = 1'b1;
    step();
    key_req = 1'b0;
    checks++; if ({key_bit_vld, key_err, keyinput} !== 3'b101) begin errors++; $display("FAIL load_req_next got %b want 101", {key_bit_vld, key_err, keyinput}); end
    checks++; if (use_cnt !== 16'd1) begin errors++; $display("FAIL load_req_cnt got %0d want 1", use_cnt); end
  endtask

  task automatic test_lease();
    clear_and_load(16'h000F);
    key_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({l_key_bit_vld, l_key_err, l_keyinput} !== 3'b101) begin errors++; $display("FAIL lease_bit%0d got %b want 101", i, {l_key_bit_vld, l_key_err, l_keyinput}); end
      checks++; if (l_expired !== (i == 3)) begin errors++; $display("FAIL lease_expired%0d got %b want %b", i, l_expired, (i == 3)); end
    end
    step();
    key_req = 1'b0;
    checks++; if ({l_key_bit_vld, l_key_err, l_keyinput} !== 3'b110) begin errors++; $display("FAIL lease_5th got %b want 110", {l_key_bit_vld, l_key_err, l_keyinput}); end
    checks++; if ({l_key_ready, l_armed, l_use_cnt} !== {2'b10, 16'd4}) begin errors++; $display("FAIL lease_state rdy/armed/cnt got %b/%b/%0d want 1/0/4", l_key_ready, l_armed, l_use_cnt); end
    checks++; if ({expired, keyinput, use_cnt} !== {2'b00, 16'd5}) begin errors++; $display("FAIL lease_unlimited exp/bit/cnt got %b/%b/%0d want 0/0/5", expired, keyinput, use_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_and_load(16'hFFFF);
    key_req = 1'b1;
    repeat (2) step();
    checks++; if ({key_bit_vld, keyinput} !== 2'b11) begin errors++; $display("FAIL rstmid_pre got %b want 11", {key_bit_vld, keyinput}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({keyinput, key_bit_vld, key_err, armed, key_ready} !== 5'b00001) begin errors++; $display("FAIL rstmid_async got %b want 00001", {keyinput, key_bit_vld, key_err, armed, key_ready}); end
    checks++; if ({bit_ptr, use_cnt} !== 20'h0) begin errors++; $display("FAIL rstmid_counters got %h want 00000", {bit_ptr, use_cnt}); end
    step();
    checks++; if ({keyinput, key_bit_vld, key_ready} !== 3'b001) begin errors++; $display("FAIL rstmid_held got %b want 001", {keyinput, key_bit_vld, key_ready}); end
    key_req = 1'b0;
    rst = 1'b0;
    step();
    checks++; if ({key_bit_vld, armed} !== 2'b00) begin errors++; $display("FAIL rstmid_release got %b want 00", {key_bit_vld, armed}); end
  endtask

  initial begin
    test_reset();
    test_idle_req();
    test_stream();
    test_zeroize();
    test_load_req();
    test_lease();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
